// File: rtl/mux_4way_16.sv
// 4-way WIDTH-bit selector for the CPU datapath: two-level 2:1 tree.
// Optional output register enabled by defining MUX4WAY16_OUTREG_EN.
module mux_4way_16 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] ab;
  logic [WIDTH-1:0] cd;
  logic [WIDTH-1:0] sel_word;

  // sel[0] picks within each pair, sel[1] picks between the pairs.
  always_comb begin
    ab       = sel[0] ? b  : a;
    cd       = sel[0] ? d  : c;
    sel_word = sel[1] ? cd : ab;
  end

`ifdef MUX4WAY16_OUTREG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      out <= '0;
    end else begin
      out <= sel_word;
    end
  end
`else
  // Combinational build keeps clk/rst on the port list for drop-in use only.
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;
  assign out            = sel_word;
`endif

endmodule

// File: tb/tb_mux_4way_16.sv
// Self-checking bench for mux_4way_16; covers the default build and,
// when MUX4WAY16_OUTREG_EN is defined, the registered build.
module tb_mux_4way_16;

  localparam logic [15:0] VA = 16'h1234;
  localparam logic [15:0] VB = 16'h9876;
  localparam logic [15:0] VC = 16'hAAAA;
  localparam logic [15:0] VD = 16'h5555;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] a   = '0;
  logic [15:0] b   = '0;
  logic [15:0] c   = '0;
  logic [15:0] d   = '0;
  logic [1:0]  sel = '0;
  logic [15:0] dut_out;

  int errors = 0;
  int checks = 0;

  mux_4way_16 #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .c   (c),
    .d   (d),
    .sel (sel),
    .out (dut_out)
  );

  always #5 clk = ~clk;

  // Reference: the four words form a table indexed by the select value.
  function automatic logic [15:0] model_mux(input logic [15:0] w0, input logic [15:0] w1,
                                            input logic [15:0] w2, input logic [15:0] w3,
                                            input logic [1:0] s);
    logic [15:0] table_w [4];
    table_w[0] = w0;
    table_w[1] = w1;
    table_w[2] = w2;
    table_w[3] = w3;
    return table_w[int'(s)];
  endfunction

  task automatic apply(input logic [15:0] na, input logic [15:0] nb,
                       input logic [15:0] nc, input logic [15:0] nd,
                       input logic [1:0] ns);
    a   = na;
    b   = nb;
    c   = nc;
    d   = nd;
    sel = ns;
  endtask

  // Combinational build: wait 10 ns. Registered build: one rising edge, then #1.
  task automatic settle();
`ifdef MUX4WAY16_OUTREG_EN
    @(posedge clk);
    #1;
`else
    #10;
`endif
  endtask

  task automatic test_reset();
    logic [15:0] exp;
    @(posedge clk);
    #1;
    rst = 1'b1;
    apply(VA, VB, VC, VD, 2'b11);
    settle();
`ifdef MUX4WAY16_OUTREG_EN
    exp = 16'h0000;
`else
    exp = model_mux(a, b, c, d, sel);
`endif
    checks++;
    if (dut_out !== exp) begin
      errors++;
      $display("FAIL reset_state: got %h expected %h", dut_out, exp);
    end
    rst = 1'b0;
  endtask

  task automatic test_zero();
    for (int s = 0; s < 4; s++) begin
      apply('0, '0, '0, '0, 2'(s));
      settle();
      checks++;
      if (dut_out !== 16'h0000) begin
        errors++;
        $display("FAIL zero_inputs sel=%0d: got %h expected 0000", s, dut_out);
      end
    end
  endtask

  task automatic test_select();
    logic [15:0] exp;
    for (int s = 0; s < 4; s++) begin
      apply(VA, VB, VC, VD, 2'(s));
      settle();
      exp = model_mux(VA, VB, VC, VD, 2'(s));
      checks++;
      if (dut_out !== exp) begin
        errors++;
        $display("FAIL select sel=%0d: got %h expected %h", s, dut_out, exp);
      end
    end
  endtask

  task automatic test_identical();
    logic [15:0] v;
    v = 16'(($urandom() & 32'hFFFF));
    for (int s = 0; s < 4; s++) begin
      apply(v, v, v, v, 2'(s));
      settle();
      checks++;
      if (dut_out !== v) begin
        errors++;
        $display("FAIL identical sel=%0d: got %h expected %h", s, dut_out, v);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  seq [4];
    logic [15:0] exp_seq [4];
    seq     = '{2'b11, 2'b00, 2'b10, 2'b01};
    exp_seq = '{16'h5555, 16'h1234, 16'hAAAA, 16'h9876};
    for (int i = 0; i < 4; i++) begin
      apply(VA, VB, VC, VD, seq[i]);
      settle();
      checks++;
      if (dut_out !== exp_seq[i]) begin
        errors++;
        $display("FAIL back_to_back step=%0d: got %h expected %h", i, dut_out, exp_seq[i]);
      end
    end
  endtask

  task automatic test_follow();
    apply(VA, VB, VC, VD, 2'b01);
    settle();
    checks++;
    if (dut_out !== 16'h9876) begin
      errors++;
      $display("FAIL follow_before: got %h expected 9876", dut_out);
    end
    apply(VA, 16'hFFFF, VC, VD, 2'b01);
    settle();
    checks++;
    if (dut_out !== 16'hFFFF) begin
      errors++;
      $display("FAIL follow_after: got %h expected ffff", dut_out);
    end
  endtask

  task automatic test_random();
    logic [15:0] exp;
    for (int i = 0; i < 64; i++) begin
      apply(16'($urandom()), 16'($urandom()), 16'($urandom()), 16'($urandom()),
            2'($urandom_range(0, 3)));
      settle();
      exp = model_mux(a, b, c, d, sel);
      checks++;
      if (dut_out !== exp) begin
        errors++;
        $display("FAIL random i=%0d sel=%0d: got %h expected %h", i, sel, dut_out, exp);
      end
    end
  endtask

`ifdef MUX4WAY16_OUTREG_EN
  task automatic test_reg_reset_sequence();
    apply(VA, VB, VC, VD, 2'b11);
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++;
    if (dut_out !== 16'h0000) begin
      errors++;
      $display("FAIL reg_reset_hold: got %h expected 0000", dut_out);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (dut_out !== 16'h5555) begin
      errors++;
      $display("FAIL reg_reset_release: got %h expected 5555", dut_out);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (dut_out !== 16'h0000) begin
      errors++;
      $display("FAIL reg_reset_midstream: got %h expected 0000", dut_out);
    end
    rst = 1'b0;
  endtask

  task automatic test_reg_hold();
    apply(VA, VB, VC, VD, 2'b10);
    settle();
    apply(VA, VB, VC, VD, 2'b00);
    #2;
    checks++;
    if (dut_out !== 16'hAAAA) begin
      errors++;
      $display("FAIL reg_hold_between_edges: got %h expected aaaa", dut_out);
    end
    settle();
    checks++;
    if (dut_out !== 16'h1234) begin
      errors++;
      $display("FAIL reg_hold_next_edge: got %h expected 1234", dut_out);
    end
  endtask
`else
  task automatic test_comb_ignores_rst();
    logic [15:0] exp;
    rst = 1'b1;
    apply(VA, VB, VC, VD, 2'b10);
    #10;
    exp = model_mux(a, b, c, d, sel);
    checks++;
    if (dut_out !== exp) begin
      errors++;
      $display("FAIL comb_rst_ignored: got %h expected %h", dut_out, exp);
    end
    rst = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_zero();
    test_select();
    test_identical();
    test_back_to_back();
    test_follow();
    test_random();
`ifdef MUX4WAY16_OUTREG_EN
    test_reg_reset_sequence();
    test_reg_hold();
`else
    test_comb_ignores_rst();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
